// File: rtl/uv_upsampler.sv
// Horizontal 2x chroma upsampler: even pixels copy the co-sited U/V sample, odd pixels
// are interpolated with a 6-tap FIR whose window is clamped at both ends of each line.
module uv_upsampler #(
  parameter int LINE_WIDTH = 320
) (
  input  logic       CLOCK_50_I,
  input  logic       resetn,
  input  logic       enable,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] U_in,
  input  logic [7:0] V_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] U_out,
  output logic [7:0] V_out,
  output logic       out_sol,
  output logic       out_eol
);

  localparam int N  = LINE_WIDTH / 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_EVEN = 3'd2,
    S_ODD  = 3'd3,
    S_LOAD = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_in_cnt, w_in_cnt_nxt;
  logic [CW-1:0]   r_k, w_k_nxt;
  logic [7:0]      r_sr_u [6];
  logic [7:0]      r_sr_v [6];
  logic            w_load_all, w_shift_in, w_shift_rep, w_clear_win;
  logic [7:0]      w_fir_u, w_fir_v;

  // Interpolating FIR with rounding; coefficients sum to 256 so flat input passes unchanged.
  function automatic logic [7:0] fir6(input logic [7:0] s0, input logic [7:0] s1,
                                      input logic [7:0] s2, input logic [7:0] s3,
                                      input logic [7:0] s4, input logic [7:0] s5);
    logic signed [31:0] acc;
    logic signed [31:0] res;
    acc = 32'sd21  * $signed({24'd0, s0}) - 32'sd52 * $signed({24'd0, s1})
        + 32'sd159 * $signed({24'd0, s2}) + 32'sd159 * $signed({24'd0, s3})
        - 32'sd52  * $signed({24'd0, s4}) + 32'sd21 * $signed({24'd0, s5})
        + 32'sd128;
    res = acc >>> 8;
    if (res < 32'sd0) begin
      fir6 = 8'd0;
    end else if (res > 32'sd255) begin
      fir6 = 8'd255;
    end else begin
      fir6 = res[7:0];
    end
  endfunction

  assign w_fir_u = fir6(r_sr_u[0], r_sr_u[1], r_sr_u[2], r_sr_u[3], r_sr_u[4], r_sr_u[5]);
  assign w_fir_v = fir6(r_sr_v[0], r_sr_v[1], r_sr_v[2], r_sr_v[3], r_sr_v[4], r_sr_v[5]);

  // State and counters register.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_in_cnt <= '0;
      r_k      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_in_cnt <= w_in_cnt_nxt;
      r_k      <= w_k_nxt;
    end
  end

  // Next-state logic; clear overrides whatever the current state decided.
  always_comb begin
    w_state_nxt  = r_state;
    w_in_cnt_nxt = r_in_cnt;
    w_k_nxt      = r_k;
    w_load_all   = 1'b0;
    w_shift_in   = 1'b0;
    w_shift_rep  = 1'b0;
    w_clear_win  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt  = S_FILL;
          w_in_cnt_nxt = '0;
          w_k_nxt      = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FILL: begin
        if (in_valid) begin
          w_in_cnt_nxt = r_in_cnt + CW'(1);
          // The first sample of a line seeds the whole window: left-edge clamp.
          if (r_in_cnt == CW'(0)) begin
            w_load_all = 1'b1;
          end else begin
            w_shift_in = 1'b1;
          end
          if (r_in_cnt == CW'(3)) begin
            w_state_nxt = S_EVEN;
          end else begin
            w_state_nxt = S_FILL;
          end
        end else begin
          w_state_nxt = S_FILL;
        end
      end
      S_EVEN: begin
        if (out_ready) begin
          w_state_nxt = S_ODD;
        end else begin
          w_state_nxt = S_EVEN;
        end
      end
      S_ODD: begin
        if (out_ready) begin
          if (r_k == CW'(N - 1)) begin
            w_state_nxt  = S_FILL;
            w_k_nxt      = '0;
            w_in_cnt_nxt = '0;
          end else if (r_in_cnt < CW'(N)) begin
            w_k_nxt     = r_k + CW'(1);
            w_state_nxt = S_LOAD;
          end else begin
            // Input exhausted: replicate the last sample (right-edge clamp).
            w_k_nxt     = r_k + CW'(1);
            w_shift_rep = 1'b1;
            w_state_nxt = S_EVEN;
          end
        end else begin
          w_state_nxt = S_ODD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          w_shift_in   = 1'b1;
          w_in_cnt_nxt = r_in_cnt + CW'(1);
          w_state_nxt  = S_EVEN;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (clear) begin
      w_state_nxt  = S_IDLE;
      w_in_cnt_nxt = '0;
      w_k_nxt      = '0;
      w_load_all   = 1'b0;
      w_shift_in   = 1'b0;
      w_shift_rep  = 1'b0;
      w_clear_win  = 1'b1;
    end else begin
      w_clear_win = 1'b0;
    end
  end

  // Sample window shift register for both channels; sr[0] is the oldest tap.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 6; i++) begin
        r_sr_u[i] <= 8'd0;
        r_sr_v[i] <= 8'd0;
      end
    end else if (w_clear_win) begin
      for (int i = 0; i < 6; i++) begin
        r_sr_u[i] <= 8'd0;
        r_sr_v[i] <= 8'd0;
      end
    end else if (w_load_all) begin
      for (int i = 0; i < 6; i++) begin
        r_sr_u[i] <= U_in;
        r_sr_v[i] <= V_in;
      end
    end else if (w_shift_in || w_shift_rep) begin
      for (int i = 0; i < 5; i++) begin
        r_sr_u[i] <= r_sr_u[i+1];
        r_sr_v[i] <= r_sr_v[i+1];
      end
      r_sr_u[5] <= w_shift_in ? U_in : r_sr_u[5];
      r_sr_v[5] <= w_shift_in ? V_in : r_sr_v[5];
    end
  end

  // Outputs depend on state and window only, so data holds steady under backpressure.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    U_out     = 8'd0;
    V_out     = 8'd0;
    out_sol   = 1'b0;
    out_eol   = 1'b0;
    case (r_state)
      S_FILL, S_LOAD: begin
        in_ready = 1'b1;
      end
      S_EVEN: begin
        out_valid = 1'b1;
        U_out     = r_sr_u[2];
        V_out     = r_sr_v[2];
        out_sol   = (r_k == CW'(0));
      end
      S_ODD: begin
        out_valid = 1'b1;
        U_out     = w_fir_u;
        V_out     = w_fir_v;
        out_eol   = (r_k == CW'(N - 1));
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uv_upsampler.sv
// Scoreboard bench for uv_upsampler: an 8-pixel instance for directed vectors and a
// 320-pixel instance checked against a clamped-index reference model.
module tb_uv_upsampler;

  logic CLOCK_50_I;
  initial begin
    CLOCK_50_I = 1'b0;
    forever #10 CLOCK_50_I = ~CLOCK_50_I;
  end

  logic a_resetn, a_enable, a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_U_in, a_V_in, a_U_out, a_V_out;
  logic a_out_sol, a_out_eol;
  logic b_resetn, b_enable, b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_U_in, b_V_in, b_U_out, b_V_out;
  logic b_out_sol, b_out_eol;

  uv_upsampler #(.LINE_WIDTH(8)) u_dut_a (
    .CLOCK_50_I(CLOCK_50_I), .resetn(a_resetn), .enable(a_enable), .clear(a_clear),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .U_in(a_U_in), .V_in(a_V_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .U_out(a_U_out), .V_out(a_V_out),
    .out_sol(a_out_sol), .out_eol(a_out_eol));

  uv_upsampler #(.LINE_WIDTH(320)) u_dut_b (
    .CLOCK_50_I(CLOCK_50_I), .resetn(b_resetn), .enable(b_enable), .clear(b_clear),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .U_in(b_U_in), .V_in(b_V_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .U_out(b_U_out), .V_out(b_V_out),
    .out_sol(b_out_sol), .out_eol(b_out_eol));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Expected entries are {U[7:0], V[7:0], sol, eol}.
  logic [17:0] a_q[$];
  logic [17:0] b_q[$];

  // Hand-computed vectors for the 8-pixel line.
  logic [7:0] t_ramp_in [4] = '{8'd0, 8'd10, 8'd20, 8'd30};
  logic [7:0] t_ramp_out[8] = '{8'd0, 8'd5, 8'd10, 8'd15, 8'd20, 8'd25, 8'd30, 8'd30};
  logic [7:0] t_step_in [4] = '{8'd255, 8'd255, 8'd0, 8'd0};
  logic [7:0] t_step_out[8] = '{8'd255, 8'd255, 8'd255, 8'd128, 8'd0, 8'd0, 8'd0, 8'd21};

  logic [7:0] b_u [160];
  logic [7:0] b_v [160];

  int  a_rdy_mode;
  bit  a_rdy_cnt_en;
  int  a_rdy_cnt;

  // Out_ready driver for instance A: 0 = always ready, 1 = random, 2 = driven by sequence.
  initial begin
    a_out_ready = 1'b1;
    forever begin
      @(posedge CLOCK_50_I);
      #1;
      if (a_rdy_mode == 0) a_out_ready = 1'b1;
      else if (a_rdy_mode == 1) a_out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor A: pops on handshake, checks held data during stalls, counts in_ready cycles.
  initial begin
    logic [17:0] cur, e, held;
    bit stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge CLOCK_50_I);
      cur = {a_U_out, a_V_out, a_out_sol, a_out_eol};
      if (a_resetn !== 1'b1) begin
        stalled = 1'b0;
      end else begin
        if (a_rdy_cnt_en && a_in_ready) a_rdy_cnt++;
        if (stalled && a_out_valid) check("a_stall_hold", int'(cur), int'(held));
        if (a_out_valid && a_out_ready) begin
          if (a_q.size() == 0) begin
            n_checks++;
            $display("FAIL a_extra_output: got 0x%0h required no output", cur);
          end else begin
            e = a_q.pop_front();
            check("a_pixel", int'(cur), int'(e));
          end
          stalled = 1'b0;
        end else begin
          stalled = a_out_valid;
          held = cur;
        end
      end
    end
  end

  // Monitor B: pops and compares on every handshake.
  initial begin
    logic [17:0] cur, e;
    forever begin
      @(negedge CLOCK_50_I);
      cur = {b_U_out, b_V_out, b_out_sol, b_out_eol};
      if (b_resetn === 1'b1 && b_out_valid && b_out_ready) begin
        if (b_q.size() == 0) begin
          n_checks++;
          $display("FAIL b_extra_output: got 0x%0h required no output", cur);
        end else begin
          e = b_q.pop_front();
          check("b_pixel", int'(cur), int'(e));
        end
      end
    end
  end

  // Reference: direct clamped-index FIR over the whole stored line.
  function automatic logic [7:0] ref_pix(input int x, input bit chan_v);
    int coef[6] = '{21, -52, 159, 159, -52, 21};
    int k, idx, acc, s;
    k = x / 2;
    if (x % 2 == 0) return chan_v ? b_v[k] : b_u[k];
    acc = 128;
    for (int j = 0; j < 6; j++) begin
      idx = k - 2 + j;
      if (idx < 0) idx = 0;
      if (idx > 159) idx = 159;
      s = chan_v ? int'(b_v[idx]) : int'(b_u[idx]);
      acc = acc + coef[j] * s;
    end
    acc = acc >>> 8;
    if (acc < 0) return 8'd0;
    if (acc > 255) return 8'd255;
    return acc[7:0];
  endfunction

  task automatic a_push8(input logic [7:0] eu[8], input logic [7:0] ev[8]);
    for (int i = 0; i < 8; i++) a_q.push_back({eu[i], ev[i], (i == 0), (i == 7)});
  endtask

  task automatic b_push(input int npix);
    for (int x = 0; x < npix; x++)
      b_q.push_back({ref_pix(x, 1'b0), ref_pix(x, 1'b1), (x == 0), (x == 319)});
  endtask

  task automatic b_randomize_line();
    for (int i = 0; i < 160; i++) begin
      b_u[i] = 8'($urandom_range(0, 255));
      b_v[i] = 8'($urandom_range(0, 255));
    end
  endtask

  // Send tasks are entered and left at posedge+1.
  task automatic a_send(input logic [7:0] u, input logic [7:0] v, input int gap);
    bit acc;
    int t;
    a_in_valid = 1'b0;
    repeat (gap) begin @(posedge CLOCK_50_I); #1; end
    a_in_valid = 1'b1; a_U_in = u; a_V_in = v;
    acc = 1'b0; t = 0;
    while (!acc && t < 200) begin
      @(negedge CLOCK_50_I);
      acc = a_in_ready;
      @(posedge CLOCK_50_I);
      #1;
      t++;
    end
    a_in_valid = 1'b0;
    if (!acc) check("a_accept_timeout", int'(acc), 1);
  endtask

  task automatic b_send(input logic [7:0] u, input logic [7:0] v);
    bit acc;
    int t;
    b_in_valid = 1'b1; b_U_in = u; b_V_in = v;
    acc = 1'b0; t = 0;
    while (!acc && t < 200) begin
      @(negedge CLOCK_50_I);
      acc = b_in_ready;
      @(posedge CLOCK_50_I);
      #1;
      t++;
    end
    b_in_valid = 1'b0;
    if (!acc) check("b_accept_timeout", int'(acc), 1);
  endtask

  task automatic a_drain(input string name);
    int t = 0;
    while (a_q.size() != 0 && t < 2000) begin @(negedge CLOCK_50_I); #1; t++; end
    check(name, a_q.size(), 0);
    @(posedge CLOCK_50_I); #1;
  endtask

  task automatic b_drain(input string name);
    int t = 0;
    while (b_q.size() != 0 && t < 5000) begin @(negedge CLOCK_50_I); #1; t++; end
    check(name, b_q.size(), 0);
    @(posedge CLOCK_50_I); #1;
  endtask

  task automatic run_a();
    int t;
    a_rdy_mode = 0; a_rdy_cnt_en = 1'b0; a_rdy_cnt = 0;
    a_enable = 1'b0; a_clear = 1'b0; a_in_valid = 1'b0; a_U_in = 8'd0; a_V_in = 8'd0;
    a_resetn = 1'b1;
    #1 a_resetn = 1'b0;
    repeat (2) @(negedge CLOCK_50_I);
    check("reset_in_ready", a_in_ready, 0);
    check("reset_out_valid", a_out_valid, 0);
    check("reset_data", int'({a_U_out, a_V_out}), 0);
    check("reset_sol_eol", int'({a_out_sol, a_out_eol}), 0);
    @(posedge CLOCK_50_I); #1 a_resetn = 1'b1;
    @(posedge CLOCK_50_I); #1;

    // Flat line: every pixel equals the input level.
    for (int i = 0; i < 8; i++) a_q.push_back({8'd100, 8'd100, (i == 0), (i == 7)});
    a_rdy_cnt = 0; a_rdy_cnt_en = 1'b1;
    a_enable = 1'b1;
    for (int i = 0; i < 4; i++) a_send(8'd100, 8'd100, 0);
    a_drain("t1_drain");
    check("t1_in_ready_cycles", a_rdy_cnt, 4);
    a_rdy_cnt_en = 1'b0;

    // Ramp on U with step on V, then swapped.
    a_push8(t_ramp_out, t_step_out);
    for (int i = 0; i < 4; i++) a_send(t_ramp_in[i], t_step_in[i], 0);
    a_drain("t2_drain");
    a_push8(t_step_out, t_ramp_out);
    for (int i = 0; i < 4; i++) a_send(t_step_in[i], t_ramp_in[i], 0);
    a_drain("t3_drain");

    // Random backpressure and input gaps must not change the sequence.
    a_rdy_mode = 1;
    for (int r = 0; r < 3; r++) begin
      a_push8(t_ramp_out, t_step_out);
      for (int i = 0; i < 4; i++) a_send(t_ramp_in[i], t_step_in[i], $urandom_range(0, 2));
    end
    a_drain("t4_drain");

    // Clear while the first odd pixel is pending.
    a_rdy_mode = 2; a_out_ready = 1'b0;
    a_q.push_back({t_ramp_out[0], t_step_out[0], 1'b1, 1'b0});
    for (int i = 0; i < 4; i++) a_send(t_ramp_in[i], t_step_in[i], 0);
    t = 0;
    do begin @(negedge CLOCK_50_I); t++; end while (!a_out_valid && t < 50);
    check("t6_even_valid", a_out_valid, 1);
    @(posedge CLOCK_50_I); #1 a_out_ready = 1'b1;
    @(posedge CLOCK_50_I); #1 a_out_ready = 1'b0; a_clear = 1'b1; a_enable = 1'b0;
    @(negedge CLOCK_50_I);
    check("t6_odd_valid", a_out_valid, 1);
    check("t6_odd_eol", a_out_eol, 0);
    @(posedge CLOCK_50_I); #1 a_clear = 1'b0;
    @(negedge CLOCK_50_I);
    check("t6_clear_out_valid", a_out_valid, 0);
    check("t6_clear_in_ready", a_in_ready, 0);
    check("t6_clear_queue", a_q.size(), 0);
    repeat (3) @(negedge CLOCK_50_I);
    check("t6_clear_stays_idle", int'({a_out_valid, a_in_ready}), 0);
    @(posedge CLOCK_50_I); #1;
    a_rdy_mode = 0; a_out_ready = 1'b1;
    a_push8(t_ramp_out, t_step_out);
    a_enable = 1'b1;
    for (int i = 0; i < 4; i++) a_send(t_ramp_in[i], t_step_in[i], 0);
    a_drain("t6_after_clear_drain");
  endtask

  task automatic run_b();
    int t;
    b_enable = 1'b0; b_clear = 1'b0; b_in_valid = 1'b0; b_U_in = 8'd0; b_V_in = 8'd0;
    b_out_ready = 1'b1;
    b_resetn = 1'b1;
    #1 b_resetn = 1'b0;
    repeat (2) @(posedge CLOCK_50_I);
    #1 b_resetn = 1'b1;
    @(posedge CLOCK_50_I); #1;

    // Three back-to-back full-width random lines.
    b_enable = 1'b1;
    for (int l = 0; l < 3; l++) begin
      b_randomize_line();
      b_push(320);
      for (int i = 0; i < 160; i++) b_send(b_u[i], b_v[i]);
    end
    b_drain("t5_drain");

    // Asynchronous reset while waiting in LOAD.
    b_enable = 1'b0;
    b_randomize_line();
    b_push(2);
    for (int i = 0; i < 4; i++) b_send(b_u[i], b_v[i]);
    t = 0;
    do begin @(negedge CLOCK_50_I); t++; end while (!b_in_ready && t < 50);
    check("t6_reach_load", b_in_ready, 1);
    check("t6_load_no_output", b_out_valid, 0);
    #1 b_resetn = 1'b0;
    #1;
    check("t6_rst_out_valid", b_out_valid, 0);
    check("t6_rst_in_ready", b_in_ready, 0);
    check("t6_rst_data", int'({b_U_out, b_V_out}), 0);
    check("t6_rst_queue", b_q.size(), 0);
    @(posedge CLOCK_50_I); #1 b_resetn = 1'b1;
    repeat (3) begin
      @(negedge CLOCK_50_I);
      check("t6_rst_idle", int'({b_out_valid, b_in_ready}), 0);
    end
    @(posedge CLOCK_50_I); #1;
    b_randomize_line();
    b_push(320);
    b_enable = 1'b1;
    for (int i = 0; i < 160; i++) b_send(b_u[i], b_v[i]);
    b_drain("t6_after_reset_drain");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, required completion");
    $fatal(1);
  end

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uv_upsampler.md
Name: uv_upsampler

Overview:
- Upstream stage of the YUV-to-RGB converter.
- Takes horizontally downsampled U/V samples (one pair per two pixels) as a valid/ready stream and produces full-rate U'/V', one pair per pixel.
- Even pixels: sample copied through. Odd pixels: 6-tap interpolating FIR with edge clamping per line.
- U'/V' (zero-extended to 32 bits by the integrator) drive the converter's U_in_RGB/V_in_RGB. Y is aligned externally by pixel order.

Parameters:
LINE_WIDTH, 320, output pixels per line; even, >= 8. N = LINE_WIDTH/2 chroma samples per line.

Ports:
CLOCK_50_I  in  1  50 MHz clock
resetn  in  1  reset
enable  in  1  level; sampled only in IDLE, starts processing
clear  in  1  synchronous abort: next state IDLE, counters/window cleared
in_valid  in  1  U_in/V_in valid
in_ready  out  1  block accepts sample this cycle
U_in  in  8  downsampled U sample
V_in  in  8  downsampled V sample
out_valid  out  1  U_out/V_out valid
out_ready  in  1  consumer accepts output this cycle
U_out  out  8  upsampled U, unsigned, clipped
V_out  out  8  upsampled V, unsigned, clipped
out_sol  out  1  qualifies first pixel of line (x=0)
out_eol  out  1  qualifies last pixel of line (x=LINE_WIDTH-1)

Behaviour:
- Reset: resetn is asynchronous, active-low; clock is CLOCK_50_I. State IDLE. Window, in_cnt, k all cleared. in_ready=0, out_valid=0, U_out=V_out=0, out_sol=out_eol=0.
- Window per channel: sr[0..5], sr[0] oldest. Before emitting pair k it holds samples k-2 .. k+3, clamped.
- Shift: sr[i] <= sr[i+1]; sr[5] <= new.
- FSM states: IDLE, FILL, EVEN, ODD, LOAD.
- IDLE:
  - in_ready=0, out_valid=0.
  - enable=1 -> FILL, with in_cnt=0, k=0.
- FILL (in_ready=1):
  - First accepted sample of the line loads all six taps.
  - Samples 2-4 shift in.
  - After the 4th acceptance (in_cnt=4) -> EVEN.
- EVEN:
  - out_valid=1; U_out = sr[2] (sample k), likewise V.
  - out_sol = (k==0).
  - On out_ready -> ODD.
- ODD:
  - out_valid=1; output is the filtered value; out_eol = (k==N-1).
  - On out_ready:
    - If k==N-1: line done; clear k, in_cnt -> FILL for next line (enable not re-sampled; only clear or reset stop).
    - Otherwise k++.
    - If in_cnt<N -> LOAD.
    - Else shift sr[5] into itself (right-edge replicate) -> EVEN.
- LOAD:
  - in_ready=1.
  - On in_valid: shift sample in, in_cnt++ -> EVEN.
- Filter:
  - acc = 21*sr0 - 52*sr1 + 159*sr2 + 159*sr3 - 52*sr4 + 21*sr5 + 128, 32-bit signed.
  - result = acc >>> 8 (arithmetic).
  - Clip: <0 -> 0, >255 -> 255. Coefficient sum is 256.
- Outputs are combinational from state and window only, with no input paths. Data is stable while out_valid=1 and out_ready=0.
- Only one handshake per cycle: outputs never accepted in FILL/LOAD, input never accepted in EVEN/ODD.
- Steady-state throughput: 2 pixels per 3 cycles with both sides always ready.
- Latency from 4th accepted sample of a line to first out_valid: 1 cycle.
- clear has priority over all transitions. Asynchronous reset mid-line discards partial line; no output after reset until enable.

Test Plan:
1. LINE_WIDTH=8; U=V=100 for 4 samples; out_ready=1 -> 8 outputs all 100; out_sol on pixel 0, out_eol on pixel 7; in_ready high exactly 4 cycles.
2. LINE_WIDTH=8; U = 0,10,20,30 -> U_out = 0,5,10,15,20,25,30,30 (right-edge replicate on last two odd pixels).
3. LINE_WIDTH=8; U = 255,255,0,0 -> U_out = 255,255(upper clip),255,128,0,0(lower clip),0,21.
4. Backpressure: test 2 with out_ready toggling randomly, in_valid gaps in FILL/LOAD -> identical output sequence; data held stable while stalled; no sample lost or duplicated.
5. LINE_WIDTH=320, three back-to-back lines of random U/V -> outputs match reference model bit-exactly; each line restarts with left clamp; 320 outputs per line.
6. clear asserted in ODD mid-line, and resetn pulsed in LOAD -> next cycle IDLE, out_valid=0, in_ready=0; after enable the next line's output matches a fresh run.
